// File: rtl/nabp_loader_pkg.sv
// Shared types and address helpers for the NABP sinogram loader and the NABP address generator.
package nabp_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic int unsigned sg_depth(input int unsigned num_angles,
                                           input int unsigned num_bins);
    return num_angles * num_bins;
  endfunction

  // Angle-major, bin-minor sinogram address.
  function automatic int unsigned sg_index(input int unsigned angle,
                                           input int unsigned bin,
                                           input int unsigned num_bins);
    return angle * num_bins + bin;
  endfunction

endpackage

// File: rtl/nabp_sinogram_loader_if.sv
// Host stream and NABP read-port signals of the sinogram loader.
interface nabp_sinogram_loader_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 15
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              abort;
  logic              kick;
  logic              nabp_done;
  logic [ADDR_W-1:0] sg_addr;
  logic [DATA_W-1:0] sg_val;
  logic              frame_done;
  logic              frame_err;

  modport slave (
    input  in_valid, in_data, in_last, abort, nabp_done, sg_addr,
    output in_ready, kick, sg_val, frame_done, frame_err
  );

  modport master (
    output in_valid, in_data, in_last, abort, nabp_done, sg_addr,
    input  in_ready, kick, sg_val, frame_done, frame_err
  );
endinterface

// File: rtl/nabp_sinogram_ram.sv
// Simple dual-port sinogram RAM: one write port, one registered read port returning 0 out of range.
module nabp_sinogram_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 23040
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok_c;
  logic              rd_ok_c;

  assign wr_ok_c = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok_c = ({1'b0, rd_addr} < DEPTH_C);

  always_ff @(posedge clk) begin
    if (we && wr_ok_c) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read register is reset so sg_val is 0 out of reset; the array itself is not.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rd_data <= '0;
    end else if (rd_ok_c) begin
      rd_data <= mem[rd_addr[IDX_W-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/nabp_sinogram_loader.sv
// Loads one sinogram frame from the host into RAM, kicks NABP, serves its reads until done, then re-arms.
module nabp_sinogram_loader
  import nabp_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned NUM_ANGLES = 180,
  parameter int unsigned NUM_BINS   = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nabp_sinogram_loader_if.slave  bus
);
  localparam int unsigned        DEPTH     = sg_depth(NUM_ANGLES, NUM_BINS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_cnt_nxt;
  logic              frame_err_nxt;
  logic              xfer_c;
  logic              we_c;

  assign xfer_c = bus.in_valid && bus.in_ready && (state == LOAD);

  // State, write counter and registered outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state          <= LOAD;
      wr_cnt         <= '0;
      bus.in_ready   <= 1'b0;
      bus.kick       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      state          <= state_nxt;
      wr_cnt         <= wr_cnt_nxt;
      bus.frame_err  <= frame_err_nxt;
      bus.in_ready   <= (state_nxt == LOAD);
      // kick launches from the KICK cycle so an abort in that cycle can still cancel it.
      bus.kick       <= (state == KICK) && (state_nxt == RUN);
      bus.frame_done <= (state_nxt == FIN);
    end
  end

  // Next-state, write enable and framing-error logic.
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    frame_err_nxt = bus.frame_err;
    we_c          = 1'b0;

    if (bus.abort) begin
      state_nxt  = LOAD;
      wr_cnt_nxt = '0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer_c) begin
            we_c = 1'b1;
            if (wr_cnt == '0) begin
              frame_err_nxt = 1'b0;
            end
            if (wr_cnt == LAST_ADDR) begin
              state_nxt  = KICK;
              wr_cnt_nxt = wr_cnt + ADDR_W'(1);
              if (!bus.in_last) begin
                frame_err_nxt = 1'b1;
              end
            end else if (bus.in_last) begin
              frame_err_nxt = 1'b1;
              wr_cnt_nxt    = '0;
            end else begin
              wr_cnt_nxt = wr_cnt + ADDR_W'(1);
            end
          end
        end
        KICK: state_nxt = RUN;
        RUN: begin
          if (bus.nabp_done) begin
            state_nxt = FIN;
          end
        end
        FIN: begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  nabp_sinogram_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we_c),
    .wr_addr (wr_cnt),
    .wr_data (bus.in_data),
    .rd_addr (bus.sg_addr),
    .rd_data (bus.sg_val)
  );

endmodule

// File: tb/tb_nabp_sinogram_loader.sv
// Scoreboard bench for nabp_sinogram_loader: small 2x4 instance for protocol cases, full-size instance for the last address.
module tb_nabp_sinogram_loader;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned S_ANG   = 2;
  localparam int unsigned S_BINS  = 4;
  localparam int unsigned S_DEPTH = 8;
  localparam int unsigned B_ANG   = 180;
  localparam int unsigned B_BINS  = 128;
  localparam int unsigned B_DEPTH = 23040;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  nabp_sinogram_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bs ();
  nabp_sinogram_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bb ();

  nabp_sinogram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ANGLES(S_ANG), .NUM_BINS(S_BINS))
    dut_s (.clk(clk), .reset_n(reset_n), .bus(bs));
  nabp_sinogram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ANGLES(B_ANG), .NUM_BINS(B_BINS))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bb));

  int n_checks = 0;
  int n_fail   = 0;
  int kick_s   = 0;
  int done_s   = 0;
  int kick_b   = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] e;

  always @(negedge clk) begin
    if (bs.kick === 1'b1) kick_s++;
    if (bs.frame_done === 1'b1) done_s++;
    if (bb.kick === 1'b1) kick_b++;
  end

  function automatic logic [DATA_W-1:0] fpat(input int i);
    return DATA_W'((i * 7) ^ (i >> 4));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bs.in_valid = 0; bs.in_data = '0; bs.in_last = 0; bs.abort = 0; bs.nabp_done = 0; bs.sg_addr = '0;
    bb.in_valid = 0; bb.in_data = '0; bb.in_last = 0; bb.abort = 0; bb.nabp_done = 0; bb.sg_addr = '0;
  endtask

  // One transfer on the small instance; waits a bounded time for in_ready.
  task automatic send_s(input logic [DATA_W-1:0] d, input logic last, input logic ab);
    int w = 0;
    while (bs.in_ready !== 1'b1 && w < 20) begin step(); w++; end
    if (bs.in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: in_ready got %b expected 1 within 20 cycles", bs.in_ready);
    end
    bs.in_valid = 1; bs.in_data = d; bs.in_last = last; bs.abort = ab;
    step();
    bs.in_valid = 0; bs.in_last = 0; bs.abort = 0;
  endtask

  task automatic load_s(input int base, input bit gap);
    for (int i = 0; i < int'(S_DEPTH); i++) begin
      if (gap && i > 0) step();
      send_s(DATA_W'(base + i), (i == int'(S_DEPTH) - 1), 1'b0);
    end
  endtask

  task automatic finish_run_s();
    bs.nabp_done = 1; step(); bs.nabp_done = 0; step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bs.in_ready); end
    n_checks++; if (bs.kick !== 1'b0) begin n_fail++; $display("FAIL rst_kick: got %b expected 0", bs.kick); end
    n_checks++; if (bs.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", bs.frame_done); end
    n_checks++; if (bs.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b expected 0", bs.frame_err); end
    n_checks++; if (bs.sg_val !== 12'h000) begin n_fail++; $display("FAIL rst_sg_val: got %h expected 000", bs.sg_val); end
    reset_n = 0;
    step();
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b expected 1", bs.in_ready); end
    n_checks++; if (bb.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready_big: got %b expected 1", bb.in_ready); end
  endtask

  task automatic test_normal_frame();
    int k0 = kick_s;
    int d0;
    int addrs [5] = '{5, 0, 7, 8, 32767};
    logic [DATA_W-1:0] exps [5] = '{12'h105, 12'h100, 12'h107, 12'h000, 12'h000};
    load_s(32'h100, 1'b0);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL norm_ready_drop: got %b expected 0", bs.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 1) begin n_fail++; $display("FAIL norm_kick_count: got %0d expected 1", kick_s - k0); end
    n_checks++; if (bs.frame_err !== 1'b0) begin n_fail++; $display("FAIL norm_frame_err: got %b expected 0", bs.frame_err); end
    for (int i = 0; i < 5; i++) begin
      bs.sg_addr = ADDR_W'(addrs[i]);
      exp_q.push_back(exps[i]);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bs.sg_val !== e) begin n_fail++; $display("FAIL norm_read[%0d]: got %h expected %h", addrs[i], bs.sg_val, e); end
    end
    d0 = done_s;
    bs.nabp_done = 1; step(); bs.nabp_done = 0;
    n_checks++; if (bs.frame_done !== 1'b1) begin n_fail++; $display("FAIL norm_frame_done: got %b expected 1", bs.frame_done); end
    step();
    n_checks++; if (bs.frame_done !== 1'b0) begin n_fail++; $display("FAIL norm_frame_done_end: got %b expected 0", bs.frame_done); end
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL norm_rearm: got %b expected 1", bs.in_ready); end
    n_checks++; if (done_s - d0 != 1) begin n_fail++; $display("FAIL norm_done_count: got %0d expected 1", done_s - d0); end
  endtask

  task automatic test_backpressure();
    int k0 = kick_s;
    load_s(32'h200, 1'b1);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b expected 0", bs.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 1) begin n_fail++; $display("FAIL bp_kick_count: got %0d expected 1", kick_s - k0); end
    for (int i = 0; i < int'(S_DEPTH); i++) begin
      bs.sg_addr = ADDR_W'(i);
      exp_q.push_back(DATA_W'(32'h200 + i));
      step();
      e = exp_q.pop_front();
      n_checks++; if (bs.sg_val !== e) begin n_fail++; $display("FAIL bp_read[%0d]: got %h expected %h", i, bs.sg_val, e); end
    end
    finish_run_s();
  endtask

  task automatic test_early_last();
    int k0 = kick_s;
    int ea [3] = '{0, 2, 7};
    send_s(12'h3A0, 1'b0, 1'b0);
    send_s(12'h3A1, 1'b0, 1'b0);
    send_s(12'h3A2, 1'b1, 1'b0);
    n_checks++; if (bs.frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err_set: got %b expected 1", bs.frame_err); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 0) begin n_fail++; $display("FAIL early_no_kick: got %0d expected 0", kick_s - k0); end
    send_s(12'h300, 1'b0, 1'b0);
    n_checks++; if (bs.frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_clear: got %b expected 0", bs.frame_err); end
    for (int i = 1; i < int'(S_DEPTH); i++) send_s(DATA_W'(32'h300 + i), (i == int'(S_DEPTH) - 1), 1'b0);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL early_ready_drop: got %b expected 0", bs.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 1) begin n_fail++; $display("FAIL early_kick_count: got %0d expected 1", kick_s - k0); end
    for (int i = 0; i < 3; i++) begin
      bs.sg_addr = ADDR_W'(ea[i]);
      exp_q.push_back(DATA_W'(32'h300 + ea[i]));
      step();
      e = exp_q.pop_front();
      n_checks++; if (bs.sg_val !== e) begin n_fail++; $display("FAIL early_read[%0d]: got %h expected %h", ea[i], bs.sg_val, e); end
    end
    finish_run_s();
  endtask

  task automatic test_missing_last();
    int k0 = kick_s;
    for (int i = 0; i < int'(S_DEPTH); i++) send_s(DATA_W'(32'h600 + i), 1'b0, 1'b0);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL miss_ready_drop: got %b expected 0", bs.in_ready); end
    n_checks++; if (bs.frame_err !== 1'b1) begin n_fail++; $display("FAIL miss_err: got %b expected 1", bs.frame_err); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 1) begin n_fail++; $display("FAIL miss_kick_count: got %0d expected 1", kick_s - k0); end
    finish_run_s();
    n_checks++; if (bs.frame_err !== 1'b1) begin n_fail++; $display("FAIL miss_err_sticky: got %b expected 1", bs.frame_err); end
  endtask

  task automatic test_abort();
    int k0;
    int d0;
    send_s(12'h400, 1'b0, 1'b0);
    send_s(12'h401, 1'b0, 1'b0);
    send_s(12'h402, 1'b0, 1'b0);
    send_s(12'h403, 1'b0, 1'b1);
    k0 = kick_s;
    for (int i = 0; i < 4; i++) send_s(DATA_W'(32'h500 + i), 1'b0, 1'b0);
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_restart_half: got %b expected 1", bs.in_ready); end
    for (int i = 4; i < int'(S_DEPTH); i++) send_s(DATA_W'(32'h500 + i), (i == int'(S_DEPTH) - 1), 1'b0);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_restart_full: got %b expected 0", bs.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 1) begin n_fail++; $display("FAIL abort_kick_count: got %0d expected 1", kick_s - k0); end
    for (int i = 0; i < int'(S_DEPTH); i++) begin
      bs.sg_addr = ADDR_W'(i);
      exp_q.push_back(DATA_W'(32'h500 + i));
      step();
      e = exp_q.pop_front();
      n_checks++; if (bs.sg_val !== e) begin n_fail++; $display("FAIL abort_read[%0d]: got %h expected %h", i, bs.sg_val, e); end
    end
    d0 = done_s;
    bs.abort = 1; step(); bs.abort = 0;
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_run_ready: got %b expected 1", bs.in_ready); end
    bs.nabp_done = 1; step(); bs.nabp_done = 0; step();
    n_checks++; if (done_s - d0 != 0) begin n_fail++; $display("FAIL abort_run_no_done: got %0d expected 0", done_s - d0); end
    k0 = kick_s;
    for (int i = 0; i < int'(S_DEPTH); i++) send_s(DATA_W'(32'h700 + i), (i == int'(S_DEPTH) - 1), 1'b0);
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_cnt_cleared: got %b expected 0", bs.in_ready); end
    bs.abort = 1; step(); bs.abort = 0;
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_kick_ready: got %b expected 1", bs.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_s - k0 != 0) begin n_fail++; $display("FAIL abort_kick_suppressed: got %0d expected 0", kick_s - k0); end
    n_checks++; if (done_s - d0 != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_s - d0); end
  endtask

  task automatic test_reset_mid_run();
    bs.sg_addr = ADDR_W'(5);
    load_s(32'h800, 1'b0);
    step();
    n_checks++; if (bs.kick !== 1'b1) begin n_fail++; $display("FAIL rrun_kick_pre: got %b expected 1", bs.kick); end
    n_checks++; if (bs.sg_val !== 12'h805) begin n_fail++; $display("FAIL rrun_sg_val_pre: got %h expected 805", bs.sg_val); end
    #2 reset_n = 1;
    #1;
    n_checks++; if (bs.kick !== 1'b0) begin n_fail++; $display("FAIL rrun_kick_async: got %b expected 0", bs.kick); end
    n_checks++; if (bs.sg_val !== 12'h000) begin n_fail++; $display("FAIL rrun_sg_val_async: got %h expected 000", bs.sg_val); end
    n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL rrun_ready_async: got %b expected 0", bs.in_ready); end
    n_checks++; if (bs.frame_done !== 1'b0) begin n_fail++; $display("FAIL rrun_done_async: got %b expected 0", bs.frame_done); end
    step();
    reset_n = 0;
    step();
    n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL rrun_ready_release: got %b expected 1", bs.in_ready); end
  endtask

  task automatic test_full_size();
    int k0 = kick_b;
    int w = 0;
    int ra [4] = '{23039, 0, 12345, 23040};
    while (bb.in_ready !== 1'b1 && w < 20) begin step(); w++; end
    for (int i = 0; i < int'(B_DEPTH); i++) begin
      bb.in_valid = 1; bb.in_data = fpat(i); bb.in_last = (i == int'(B_DEPTH) - 1);
      step();
    end
    bb.in_valid = 0; bb.in_last = 0;
    n_checks++; if (bb.in_ready !== 1'b0) begin n_fail++; $display("FAIL big_ready_drop: got %b expected 0", bb.in_ready); end
    repeat (3) step();
    n_checks++; if (kick_b - k0 != 1) begin n_fail++; $display("FAIL big_kick_count: got %0d expected 1", kick_b - k0); end
    for (int i = 0; i < 4; i++) begin
      bb.sg_addr = ADDR_W'(ra[i]);
      exp_q.push_back((ra[i] < int'(B_DEPTH)) ? fpat(ra[i]) : 12'h000);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bb.sg_val !== e) begin n_fail++; $display("FAIL big_read[%0d]: got %h expected %h", ra[i], bb.sg_val, e); end
    end
    bb.nabp_done = 1; step(); bb.nabp_done = 0;
    n_checks++; if (bb.frame_done !== 1'b1) begin n_fail++; $display("FAIL big_frame_done: got %b expected 1", bb.frame_done); end
    n_checks++; if (bb.frame_err !== 1'b0) begin n_fail++; $display("FAIL big_frame_err: got %b expected 0", bb.frame_err); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_abort();
    test_reset_mid_run();
    test_full_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nabp_sinogram_loader.md
Name: nabp_sinogram_loader

Overview:
- Upstream feeder for the NABP top level.
- Accepts a sinogram frame from the host as a valid/ready word stream and stores it in an on-chip dual-port sinogram RAM.
- Once a full frame is stored, pulses kick to NABP, then serves NABP's sg_addr reads with one-cycle latency until NABP asserts done.
- Reports frame completion and framing errors to the host, then re-arms for the next frame.

Parameters:
- DATA_W, 12, sinogram sample width; equals kDataLength.
- ADDR_W, 15, sinogram address width; equals kSinogramAddressLength.
- NUM_ANGLES, 180, projection angles per frame.
- NUM_BINS, 128, detector bins per angle. Constraint: NUM_ANGLES*NUM_BINS <= 2^ADDR_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-high.
- in_valid  in  1  host sample valid.
- in_data  in  DATA_W  host sample; ordered angle-major, bin-minor.
- in_last  in  1  host marks final sample of frame.
- in_ready  out  1  loader can accept a sample.
- abort  in  1  host abort; discard partial frame.
- kick  out  1  one-cycle start pulse to NABP.
- nabp_done  in  1  NABP finished the frame.
- sg_addr  in  ADDR_W  NABP read address.
- sg_val  out  DATA_W  read data.
- frame_done  out  1  one-cycle pulse to host.
- frame_err  out  1  sticky framing error.

Behaviour:
- DEPTH = NUM_ANGLES*NUM_BINS. Write address = running count wr_cnt (ADDR_W bits), equivalent to angle*NUM_BINS+bin.
- Reset values: in_ready=0, kick=0, sg_val=0, frame_done=0, frame_err=0, wr_cnt=0, state=LOAD. Reset mid-operation returns to these values immediately; RAM contents are undefined.
- States: LOAD, KICK, RUN, FIN.
- LOAD:
  - in_ready=1 (registered; first 1 is the cycle after reset release).
  - A transfer occurs on in_valid&&in_ready. It writes in_data at wr_cnt, then wr_cnt++.
  - A transfer with wr_cnt==DEPTH-1 goes to KICK.
  - If in_last on that final transfer is 0, set frame_err.
  - If in_last=1 on any earlier transfer, set frame_err, reset wr_cnt=0, stay in LOAD; the partial frame is dropped.
- KICK:
  - Lasts exactly 1 cycle; kick=1, in_ready=0. Go to RUN.
- RUN:
  - in_ready=0.
  - Wait for nabp_done; nabp_done is sampled only in RUN. On it, go to FIN.
- FIN:
  - Lasts 1 cycle; frame_done=1, wr_cnt=0. Go to LOAD.
- abort:
  - Applies in any state. Next state is LOAD, wr_cnt=0.
  - No frame_done; kick is suppressed if abort coincides with the KICK cycle.
  - abort takes priority over a simultaneous transfer; the write is dropped.
- Read port:
  - sg_val <= RAM[sg_addr] registered, 1-cycle latency, active in all states.
  - An out-of-range sg_addr (>=DEPTH) returns 0.
  - A read of the address written in the same cycle returns old data; reads during LOAD are unspecified to NABP.
- frame_err is sticky. It is cleared only by reset or by an accepted first sample (wr_cnt==0) of a new frame in LOAD; set has priority over clear in the same cycle.
- kick and frame_done are never asserted for more than 1 consecutive cycle.

Decomposition:
- Shared package `nabp_loader_pkg`:
  - state enum {LOAD, KICK, RUN, FIN};
  - DEPTH localparam function;
  - the address-mapping helper angle*NUM_BINS+bin, reused by the NABP address generator.
- Sub-module `nabp_sinogram_ram`: simple dual-port synchronous RAM with one write port and one registered read port, parameterised DATA_W/ADDR_W/DEPTH.

Test Plan (NUM_ANGLES=2, NUM_BINS=4, DEPTH=8 unless noted):
- Normal frame: stream 0x100..0x107 with in_last on the 8th sample, in_valid held 1.
  - in_ready drops the cycle after the 8th transfer.
  - kick=1 for exactly 1 cycle.
  - sg_addr=5 returns sg_val=0x105 one cycle later.
  - nabp_done -> frame_done pulse on the next cycle, then in_ready=1.
- Backpressure/gaps: in_valid toggled 1,0,1,… over 8 samples -> exactly 8 writes, RAM holds correct ordering, single kick.
- Early last: in_last on the 3rd sample -> frame_err=1, no kick. A following correct 8-sample frame loads and kicks, and frame_err clears on its first sample.
- Missing last: 8 samples with in_last=0 -> kick still issued, frame_err=1.
- Abort: abort asserted in RUN -> state LOAD, wr_cnt=0, no frame_done; abort coincident with the 4th sample -> that sample is not written.
- Reset mid-RUN: reset_n pulsed -> kick/frame_done/sg_val=0 asynchronously, in_ready=1 one cycle after release. Full-size params (180x128): last address 23039 reads back the final sample.
